// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: accumulator width helpers, mean-threshold FSM states, default threshold.
// Latency: n/a (compile-time constants and types only).
// Backpressure: n/a.
package img_pkg;

  // Default binarisation threshold, also used by the segmentation stage.
  localparam logic [7:0] INIT_THRESHOLD_DEF = 8'd100;

  // Width of a counter that must hold h*v pixels.
  function automatic int calc_cnt_w(input int h, input int v);
    return $clog2(h * v + 1);
  endfunction

  // Width of an accumulator that must hold h*v pixels of value 255.
  function automatic int calc_sum_w(input int h, input int v);
    return $clog2(h * v * 255 + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV    = 2'd1,
    COMMIT = 2'd2
  } mt_state_t;

endpackage

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per cycle, quotient saturated to Q_W bits.
// Latency: done pulses DVD_W cycles after start is accepted; quotient holds until the next start.
// Backpressure: start is ignored while busy; the caller must wait for done.
module serial_divider #(
  parameter int DVD_W = 27,
  parameter int DVS_W = 19,
  parameter int Q_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int IT_W = $clog2(DVD_W + 1);

  logic             busy_q, busy_d;
  logic [IT_W-1:0]  iter_q, iter_d;
  logic [DVD_W-1:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;

  logic [DVS_W:0]   rem_sh;
  logic [DVS_W:0]   rem_sub;
  logic             fits;
  logic             last;

  // One restoring step plus start/iteration bookkeeping.
  always_comb begin
    busy_d  = busy_q;
    iter_d  = iter_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    rem_sh  = {rem_q, dvd_q[DVD_W-1]};
    fits    = (rem_sh >= {1'b0, dvs_q});
    rem_sub = fits ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    last    = busy_q && (iter_q == IT_W'(DVD_W - 1));
    if (start && !busy_q) begin
      busy_d = 1'b1;
      iter_d = '0;
      dvd_d  = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
    end else if (busy_q) begin
      // Remainder stays below the divisor, so the top bit of rem_sub is always zero here.
      dvd_d  = {dvd_q[DVD_W-2:0], fits};
      rem_d  = rem_sub[DVS_W-1:0];
      iter_d = iter_q + IT_W'(1);
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      iter_q <= '0;
      dvd_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      iter_q <= iter_d;
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  // Saturate the full-width quotient into Q_W bits.
  always_comb begin
    quotient = dvd_q[Q_W-1:0];
    if (|dvd_q[DVD_W-1:Q_W]) begin
      quotient = '1;
    end
  end

  assign busy = busy_q;
  assign done = last;

endmodule

// File: rtl/frame_mean_threshold.sv
// Per-frame mean of Y committed as the next binarisation threshold; Y stream passed through one register.
// Latency: pass-through 1 cycle; threshold commits >= SUM_W+1 cycles after the vsync rising edge, outside Y_de.
// Backpressure: none; a frame edge arriving while a division is pending is dropped. Option macro: MEAN_THRESH_CLAMP_EN.
module frame_mean_threshold
  import img_pkg::*;
#(
  parameter int         H_DISP         = 640,
  parameter int         V_DISP         = 480,
  parameter logic [7:0] INIT_THRESHOLD = INIT_THRESHOLD_DEF,
  parameter logic [7:0] TH_MIN         = 8'd16,
  parameter logic [7:0] TH_MAX         = 8'd240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Y_hsync,
  input  logic       Y_vsync,
  input  logic [7:0] Y_data,
  input  logic       Y_de,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic [7:0] out_data,
  output logic       out_de,
  output logic [7:0] threshold,
  output logic       th_valid,
  output logic       th_update
);

  localparam int SUM_W = calc_sum_w(H_DISP, V_DISP);
  localparam int CNT_W = calc_cnt_w(H_DISP, V_DISP);

  logic             vsync_q;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mt_state_t        state_q, state_d;
  logic [7:0]       threshold_q, threshold_d;
  logic             th_valid_q, th_valid_d;
  logic             hsync_q, vsync_o_q, de_q;
  logic [7:0]       data_q;

  logic             frame_edge;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [7:0]       div_q;
  logic [7:0]       commit_val;
  logic             commit;

  assign frame_edge = Y_vsync && !vsync_q;
  assign div_start  = frame_edge && (cnt_q != '0) && (state_q == IDLE) && !div_busy;

  // Pixel accumulation; the edge cycle restarts the sums, keeping its own pixel for the new frame.
  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (frame_edge) begin
      sum_d = Y_de ? SUM_W'(Y_data) : '0;
      cnt_d = Y_de ? CNT_W'(1) : '0;
    end else if (Y_de) begin
      sum_d = sum_q + SUM_W'(Y_data);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  serial_divider #(
    .DVD_W (SUM_W),
    .DVS_W (CNT_W),
    .Q_W   (8)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sum_q),
    .divisor  (cnt_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

`ifdef MEAN_THRESH_CLAMP_EN
  // Keep the committed threshold inside the configured window.
  always_comb begin
    commit_val = div_q;
    if (div_q < TH_MIN) begin
      commit_val = TH_MIN;
    end else if (div_q > TH_MAX) begin
      commit_val = TH_MAX;
    end
  end
`else
  // Clamp bounds only matter in the clamped build.
  logic unused_clamp_bounds;
  assign unused_clamp_bounds = ^{TH_MIN, TH_MAX};
  assign commit_val = div_q;
`endif

  // Division sequencing; the commit waits for blanking so a frame never sees two thresholds.
  always_comb begin
    state_d     = state_q;
    commit      = 1'b0;
    threshold_d = threshold_q;
    th_valid_d  = th_valid_q;
    unique case (state_q)
      IDLE: begin
        if (div_start) begin
          state_d = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (!Y_de) begin
          commit      = 1'b1;
          threshold_d = commit_val;
          th_valid_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control, accumulator and pass-through registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      sum_q       <= '0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      threshold_q <= INIT_THRESHOLD;
      th_valid_q  <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_o_q   <= 1'b0;
      data_q      <= '0;
      de_q        <= 1'b0;
    end else begin
      vsync_q     <= Y_vsync;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      threshold_q <= threshold_d;
      th_valid_q  <= th_valid_d;
      hsync_q     <= Y_hsync;
      vsync_o_q   <= Y_vsync;
      data_q      <= Y_data;
      de_q        <= Y_de;
    end
  end

  assign out_hsync = hsync_q;
  assign out_vsync = vsync_o_q;
  assign out_data  = data_q;
  assign out_de    = de_q;
  assign threshold = threshold_q;
  assign th_valid  = th_valid_q;
  assign th_update = commit;

endmodule

// File: tb/tb_frame_mean_threshold.sv
// Bench for frame_mean_threshold: directed frames plus random sync/data traffic against a frame-level mean model.
// Latency: model assumes a commit window opening 28 cycles after each accepted vsync rising edge.
// Backpressure: n/a.
module tb_frame_mean_threshold;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Y_hsync = 1'b0;
  logic       Y_vsync = 1'b0;
  logic [7:0] Y_data = 8'd0;
  logic       Y_de = 1'b0;
  logic       out_hsync, out_vsync, out_de, th_valid, th_update;
  logic [7:0] out_data, threshold;

  localparam int DIV_LAT = 28;
`ifdef MEAN_THRESH_CLAMP_EN
  localparam int EXP_Y5 = 16;
`else
  localparam int EXP_Y5 = 5;
`endif

  frame_mean_threshold dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Y_hsync   (Y_hsync),
    .Y_vsync   (Y_vsync),
    .Y_data    (Y_data),
    .Y_de      (Y_de),
    .out_hsync (out_hsync),
    .out_vsync (out_vsync),
    .out_data  (out_data),
    .out_de    (out_de),
    .threshold (threshold),
    .th_valid  (th_valid),
    .th_update (th_update)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int upd_seen = 0;

  // Frame-level model state.
  int  m_cyc = 0;
  int  m_sum = 0;
  int  m_cnt = 0;
  bit  m_prev_vs = 1'b0;
  bit  m_pending = 1'b0;
  int  m_ready = 0;
  int  m_val = 0;
  int  exp_th = 100;
  bit  exp_valid = 1'b0;
  bit  exp_oh = 1'b0, exp_ov = 1'b0, exp_ode = 1'b0;
  int  exp_od = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int mean_to_threshold(input int s, input int c);
    int q;
    q = s / c;
    if (q > 255) q = 255;
`ifdef MEAN_THRESH_CLAMP_EN
    if (q < 16) q = 16;
    if (q > 240) q = 240;
`endif
    return q;
  endfunction

  // Per-cycle comparison against the model, then advance the model with this cycle's inputs.
  task automatic model_step();
    bit commit;
    bit edge_now;
    if (!rst_n) begin
      m_sum = 0; m_cnt = 0; m_prev_vs = 1'b0; m_pending = 1'b0;
      exp_th = 100; exp_valid = 1'b0;
      exp_oh = 1'b0; exp_ov = 1'b0; exp_ode = 1'b0; exp_od = 0;
    end
    commit = rst_n && m_pending && (m_cyc >= m_ready) && !Y_de;
    check("th_update", th_update, commit);
    check("threshold", threshold, exp_th);
    check("th_valid", th_valid, exp_valid);
    check("out_hsync", out_hsync, exp_oh);
    check("out_vsync", out_vsync, exp_ov);
    check("out_data", out_data, exp_od);
    check("out_de", out_de, exp_ode);
    if (th_update) upd_seen++;
    if (rst_n) begin
      exp_oh = Y_hsync; exp_ov = Y_vsync; exp_od = Y_data; exp_ode = Y_de;
      edge_now = Y_vsync && !m_prev_vs;
      if (commit) begin
        exp_th = m_val;
        exp_valid = 1'b1;
      end
      if (edge_now) begin
        if (m_cnt != 0 && !m_pending) begin
          m_pending = 1'b1;
          m_ready = m_cyc + DIV_LAT;
          m_val = mean_to_threshold(m_sum, m_cnt);
        end
        m_sum = Y_de ? int'(Y_data) : 0;
        m_cnt = Y_de ? 1 : 0;
      end else if (Y_de) begin
        m_sum += int'(Y_data);
        m_cnt += 1;
      end
      if (commit) m_pending = 1'b0;
      m_prev_vs = Y_vsync;
    end
    m_cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Active frame of `lines` lines, left half vl and right half vr, then drive the vsync edge cycle.
  task automatic frame(input int vl, input int vr, input int w, input int lines);
    Y_vsync = 1'b0;
    for (int l = 0; l < lines; l++) begin
      for (int x = 0; x < w; x++) begin
        Y_hsync = 1'b0; Y_de = 1'b1;
        Y_data = 8'((x < w / 2) ? vl : vr);
        tick();
      end
      for (int b = 0; b < 4; b++) begin
        Y_hsync = 1'b1; Y_de = 1'b0; Y_data = 8'($urandom);
        tick();
      end
    end
    Y_hsync = 1'b0; Y_de = 1'b0; Y_vsync = 1'b1;
  endtask

  initial begin
    // Reset state.
    repeat (3) tick();
    check("rst_threshold", threshold, 100);
    check("rst_th_valid", th_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_de", out_de, 0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Uniform Y=200: commit cycle is edge+28, new threshold visible one cycle later.
    upd_seen = 0;
    frame(200, 200, 32, 8);
    repeat (DIV_LAT) tick();
    #1;
    check("t200_upd_at_commit", th_update, 1);
    check("t200_th_before", threshold, 100);
    tick();
    check("t200_th", threshold, 200);
    check("t200_valid", th_valid, 1);
    check("t200_upd_after", th_update, 0);
    repeat (5) tick();
    check("t200_pulses", upd_seen, 1);
    Y_vsync = 1'b0;
    repeat (3) tick();

    // Half 0 / half 255: mean 127.5 floors to 127.
    frame(0, 255, 32, 8);
    repeat (35) tick();
    check("half_th", threshold, 127);
    Y_vsync = 1'b0;
    repeat (3) tick();

    // Dark frame: raw 5, clamped 16.
    frame(5, 5, 32, 8);
    repeat (35) tick();
    check("dark_th", threshold, EXP_Y5);

    // Edges with no pixels between them change nothing.
    upd_seen = 0;
    Y_vsync = 1'b0; repeat (3) tick();
    Y_vsync = 1'b1; repeat (3) tick();
    Y_vsync = 1'b0; repeat (3) tick();
    Y_vsync = 1'b1; repeat (40) tick();
    check("empty_th", threshold, EXP_Y5);
    check("empty_pulses", upd_seen, 0);
    Y_vsync = 1'b0;
    tick();

    // Active pixels over edge+28..edge+40 postpone the commit to edge+41.
    frame(60, 60, 32, 8);
    repeat (DIV_LAT - 1) tick();
    upd_seen = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      Y_de = 1'b1; Y_data = 8'($urandom);
    end
    tick();
    Y_de = 1'b0;
    #1;
    check("held_upd_at_41", th_update, 1);
    check("held_no_early_pulse", upd_seen, 0);
    check("held_th_before", threshold, EXP_Y5);
    tick();
    check("held_th", threshold, 60);
    Y_vsync = 1'b0;
    tick();

    // Reset during division: nothing commits afterwards.
    frame(90, 90, 32, 8);
    repeat (10) tick();
    rst_n = 1'b0;
    upd_seen = 0;
    #1;
    check("mid_rst_threshold", threshold, 100);
    check("mid_rst_valid", th_valid, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("post_rst_threshold", threshold, 100);
    check("post_rst_valid", th_valid, 0);
    check("post_rst_pulses", upd_seen, 0);

    // Random syncs and data, checked cycle by cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      Y_data  = 8'($urandom);
      Y_hsync = 1'($urandom_range(0, 1));
      Y_de    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) Y_vsync = ~Y_vsync;
      tick();
    end
    Y_de = 1'b0;
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
